// File: rtl/comp_arb_pkg.sv
// Shared types and constants for comp_arbiter: FSM states, comparison op codes,
// and the all-ones code reported for a false or illegal comparison.
package comp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NEQ = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b010;
    localparam logic [2:0] OP_LTE = 3'b011;
    localparam logic [2:0] OP_GT  = 3'b100;
    localparam logic [2:0] OP_GTE = 3'b101;

    // Wide enough for any supported N; users slice the low N bits.
    localparam int unsigned            CODE_MAX_W = 64;
    localparam logic [CODE_MAX_W-1:0] CODE_FALSE = '1;

endpackage

// File: rtl/comp_arbiter_comparators.sv
// Unsigned N-bit comparator bank: evaluates one op and produces the raw result
// code (op zero-extended when true, all-ones when false or illegal).
module comp_arbiter_comparators
    import comp_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic [N-1:0] code,
    output logic         is_true,
    output logic         err
);

    always_comb begin
        is_true = 1'b0;
        err     = 1'b0;
        case (op)
            OP_EQ:   is_true = (a == b);
            OP_NEQ:  is_true = (a != b);
            OP_LT:   is_true = (a <  b);
            OP_LTE:  is_true = (a <= b);
            OP_GT:   is_true = (a >  b);
            OP_GTE:  is_true = (a >= b);
            default: err     = 1'b1;
        endcase
        code = is_true ? N'(op) : CODE_FALSE[N-1:0];
    end

endmodule

// File: rtl/comp_arbiter.sv
// Two-requester comparison arbiter: IDLE grants one requester, CMP evaluates,
// RESP holds the result until taken. COMP_ARB_FIXED_PRIO_EN makes req0 always win.
module comp_arbiter
    import comp_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic         rsp_true,
    output logic [N-1:0] rsp_code,
    output logic         rsp_err,
    output logic         busy
);

    state_t       state_q, state_d;
    logic [N-1:0] a_q, b_q;
    logic [2:0]   op_q;
    logic         id_q;
    logic         grant_id;
    logic         any_valid;
    logic         hs;
    logic [N-1:0] cmp_code;
    logic         cmp_true, cmp_err;

    assign any_valid = req0_valid | req1_valid;
    assign hs        = (state_q == ST_IDLE) && any_valid;

`ifdef COMP_ARB_FIXED_PRIO_EN
    assign grant_id = ~req0_valid;
`else
    // last_q holds the most recent grant; reset value 1 makes req0 win first.
    logic last_q;

    assign grant_id = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_q <= 1'b1;
        else if (hs)
            last_q <= grant_id;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Ready is gated by reset_n so both readies drop the instant reset asserts.
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid && reset_n) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_d    = ST_CMP;
                end
            end
            ST_CMP:  state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            id_q <= 1'b0;
        end else if (hs) begin
            a_q  <= grant_id ? req1_a  : req0_a;
            b_q  <= grant_id ? req1_b  : req0_b;
            op_q <= grant_id ? req1_op : req0_op;
            id_q <= grant_id;
        end
    end

    comp_arbiter_comparators #(.N(N)) u_cmp (
        .a       (a_q),
        .b       (b_q),
        .op      (op_q),
        .code    (cmp_code),
        .is_true (cmp_true),
        .err     (cmp_err)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_id   <= 1'b0;
            rsp_true <= 1'b0;
            rsp_code <= '0;
            rsp_err  <= 1'b0;
        end else if (state_q == ST_CMP) begin
            rsp_id   <= id_q;
            rsp_true <= cmp_true;
            rsp_code <= cmp_code;
            rsp_err  <= cmp_err;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_comp_arbiter.sv
// Randomized + directed bench for comp_arbiter against a phase-level reference
// model; define COMP_ARB_FIXED_PRIO_EN here too when building the fixed-priority variant.
module tb_comp_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         v0, v1, rr;
    logic [N-1:0] a0, b0, a1, b1;
    logic [2:0]   op0, op1;
    logic         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_true, rsp_err, busy;
    logic [N-1:0] rsp_code;

    comp_arbiter #(.N(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (v0),
        .req0_ready (req0_ready),
        .req0_a     (a0),
        .req0_b     (b0),
        .req0_op    (op0),
        .req1_valid (v1),
        .req1_ready (req1_ready),
        .req1_a     (a1),
        .req1_b     (b1),
        .req1_op    (op1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rr),
        .rsp_id     (rsp_id),
        .rsp_true   (rsp_true),
        .rsp_code   (rsp_code),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 evaluating, 2 response held.
    int           mst;
    bit           m_last;
    bit           e_id, e_true, e_err;
    logic [N-1:0] e_code;
    bit           g_id, g_true, g_err;
    logic [N-1:0] g_code;
    bit           hs0, hs1, done, prev_rv;
    int           cyc, hs_cyc, rv_cyc;
    int           grant_q[$];

    function automatic void ref_cmp(input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic [2:0] op, output bit t, output bit err,
                                    output logic [N-1:0] code);
        int d;
        d   = int'(a) - int'(b);
        t   = 1'b0;
        err = 1'b0;
        case (op)
            3'd0:    t = (d == 0);
            3'd1:    t = (d != 0);
            3'd2:    t = (d < 0);
            3'd3:    t = (d <= 0);
            3'd4:    t = (d > 0);
            3'd5:    t = (d >= 0);
            default: err = 1'b1;
        endcase
        code = t ? {{(N-3){1'b0}}, op} : {N{1'b1}};
    endfunction

    task automatic sample();
        bit er0, er1, g;
        hs0 = 0; hs1 = 0; done = 0;
        er0 = 0; er1 = 0; g = 0;
        if (mst == 0 && (v0 || v1)) begin
`ifdef COMP_ARB_FIXED_PRIO_EN
            g = !v0;
`else
            g = (v0 && v1) ? !m_last : v1;
`endif
            er0 = !g;
            er1 = g;
        end
        chk("req0_ready", req0_ready, er0);
        chk("req1_ready", req1_ready, er1);
        chk("busy", busy, mst != 0);
        chk("rsp_valid", rsp_valid, mst == 2);
        if (rsp_valid && !prev_rv) rv_cyc = cyc;
        prev_rv = rsp_valid;
        case (mst)
            0: if (er0 || er1) begin
                if (g) ref_cmp(a1, b1, op1, e_true, e_err, e_code);
                else   ref_cmp(a0, b0, op0, e_true, e_err, e_code);
                e_id   = g;
                m_last = g;
                hs0    = er0;
                hs1    = er1;
                hs_cyc = cyc;
                grant_q.push_back(int'(g));
                mst    = 1;
            end
            1: mst = 2;
            default: begin
                chk("rsp_id", rsp_id, e_id);
                chk("rsp_true", rsp_true, e_true);
                chk("rsp_code", rsp_code, e_code);
                chk("rsp_err", rsp_err, e_err);
                if (rr) begin
                    g_id = rsp_id; g_true = rsp_true; g_code = rsp_code; g_err = rsp_err;
                    done = 1;
                    mst  = 0;
                end
            end
        endcase
        cyc++;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        #1 sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_true", rsp_true, 0);
        chk("rst_rsp_code", rsp_code, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        mst = 0; m_last = 1; prev_rv = 0; hs0 = 0; hs1 = 0; done = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic one_req(input bit id, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [2:0] op, input int hold);
        int guard, held, pre;
        guard = 0; held = 0;
        v0 = !id; v1 = id;
        if (id) begin a1 = a; b1 = b; op1 = op; end
        else    begin a0 = a; b0 = b; op0 = op; end
        rr = (hold == 0);
        done = 0;
        while (!done && guard < 30) begin
            pre = mst;
            step();
            if (hs0 || hs1) begin v0 = 0; v1 = 0; end
            if (pre == 2 && !done) begin
                held++;
                if (held >= hold) rr = 1;
            end
            guard++;
        end
        if (!done) chk("req_timeout", 1, 0);
        rr = 1;
    endtask

    function automatic logic [N-1:0] rnd_val();
        return ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 3)) : N'($urandom);
    endfunction

    initial begin
        int guard, ndone;
        reset_n = 1'b0; v0 = 0; v1 = 0; rr = 1;
        a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
        cyc = 0; hs_cyc = 0; rv_cyc = 0;
        @(negedge clk);
        v0 = 1;  // readies must stay low while reset is held
        do_reset();
        v0 = 0;

        one_req(0, 8'd5, 8'd5, 3'b000, 0);
        chk("s1_latency", rv_cyc - hs_cyc, 2);
        chk("s1_id", g_id, 0);
        chk("s1_true", g_true, 1);
        chk("s1_code", g_code, 8'h00);

        one_req(1, 8'd3, 8'd9, 3'b100, 0);
        chk("s2_id", g_id, 1);
        chk("s2_true", g_true, 0);
        chk("s2_code", g_code, 8'hFF);
        chk("s2_err", g_err, 0);

        one_req(0, 8'd1, 8'd1, 3'b110, 0);
        chk("s4_err", g_err, 1);
        chk("s4_true", g_true, 0);
        chk("s4_code", g_code, 8'hFF);

        one_req(1, 8'd7, 8'd2, 3'b101, 5);
        chk("s5_true", g_true, 1);
        chk("s5_code", g_code, 8'h05);

        // Contention straight after reset.
        do_reset();
        grant_q.delete();
        v0 = 1; v1 = 1; rr = 1;
        a0 = rnd_val(); b0 = rnd_val(); op0 = 3'($urandom_range(0, 7));
        a1 = rnd_val(); b1 = rnd_val(); op1 = 3'($urandom_range(0, 7));
        ndone = 0; guard = 0;
        while (ndone < 4 && guard < 40) begin
            step();
            if (hs0) begin a0 = rnd_val(); b0 = rnd_val(); op0 = 3'($urandom_range(0, 7)); end
            if (hs1) begin a1 = rnd_val(); b1 = rnd_val(); op1 = 3'($urandom_range(0, 7)); end
            if (done) ndone++;
            guard++;
        end
        v0 = 0; v1 = 0;
        if (ndone < 4 || grant_q.size() < 4) chk("s3_timeout", 1, 0);
        else begin
`ifdef COMP_ARB_FIXED_PRIO_EN
            for (int i = 0; i < 4; i++) chk("s3_grant", grant_q[i], 0);
`else
            for (int i = 0; i < 4; i++) chk("s3_grant", grant_q[i], i % 2);
`endif
        end
        step();  // let the final response retire to IDLE

        // Reset while the request is being evaluated.
        v0 = 1; a0 = 8'd4; b0 = 8'd4; op0 = 3'b000; rr = 1;
        guard = 0;
        while (mst != 1 && guard < 10) begin
            step();
            if (hs0) v0 = 0;
            guard++;
        end
        chk("s6_in_cmp", busy, 1);
        v0 = 0;
        do_reset();
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                step();
                if (rsp_valid) seen++;
            end
            chk("s6_no_rsp", seen, 0);
        end

        // Randomized traffic, including requesters withdrawing while not granted.
        for (int c = 0; c < 600; c++) begin
            if (hs0 || !v0) begin
                v0 = ($urandom_range(0, 9) < 6);
                a0 = rnd_val(); b0 = rnd_val(); op0 = 3'($urandom_range(0, 7));
            end else if ($urandom_range(0, 19) == 0) v0 = 0;
            if (hs1 || !v1) begin
                v1 = ($urandom_range(0, 9) < 6);
                a1 = rnd_val(); b1 = rnd_val(); op1 = 3'($urandom_range(0, 7));
            end else if ($urandom_range(0, 19) == 0) v1 = 0;
            rr = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/comp_arbiter.md
COMP_ARBITER -- requirements
Module: comp_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, operand and result-code width.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester has a comparison pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester's operands are accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  N  unsigned operands.
REQ-007 SHALL have ports req0_op / req1_op  input  3  op code: 000 eq, 001 neq, 010 lt, 011 lte, 100 gt, 101 gte; 110 and 111 are illegal.
REQ-008 SHALL have port rsp_valid  output  1  response is held.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes the response.
REQ-010 SHALL have port rsp_id  output  1  granted requester (0 or 1).
REQ-011 SHALL have port rsp_true  output  1  comparison result.
REQ-012 SHALL have port rsp_code  output  N  raw comparator code: the op code zero-extended when true, all-ones when false.
REQ-013 SHALL have port rsp_err  output  1  op was illegal.
REQ-014 SHALL have port busy  output  1  FSM not in IDLE.

Function
REQ-015 SHALL use a three-state FSM: IDLE -> CMP -> RESP -> IDLE.
REQ-016 In IDLE, the FSM SHALL assert ready to exactly one requester that has valid high, chosen by the arbiter; both ready outputs SHALL be low in CMP and RESP.
REQ-017 On a valid&ready handshake, the FSM SHALL register a, b, op and id, then go to CMP.
REQ-018 In CMP, the FSM SHALL register the comparator output into rsp_code, rsp_true and rsp_err, then go to RESP.
REQ-019 In RESP, rsp_valid SHALL be 1 and all rsp_* outputs SHALL hold stable until rsp_valid&rsp_ready, then the FSM returns to IDLE.
REQ-020 Latency SHALL be: handshake at edge t -> rsp_valid high after edge t+2; peak throughput is one comparison per 3 cycles.
REQ-021 rsp_true SHALL equal (rsp_code != all-ones) for legal ops.
REQ-022 For op 110/111: rsp_err=1, rsp_true=0, rsp_code=all-ones, and the response SHALL still be delivered.
REQ-023 Round-robin arbitration: with both valid, grant the requester not granted last; with one valid, grant it; the pointer updates only on a handshake.
REQ-024 When rsp_ready is high on RESP entry, the response SHALL complete in one RESP cycle; the next grant SHALL occur no earlier than the following IDLE cycle.
REQ-025 A requester dropping valid while not granted SHALL cause no state change.

Reset
REQ-026 reset_n low SHALL immediately force: state IDLE, pointer favouring req0, rsp_valid=0, rsp_id=0, rsp_true=0, rsp_code=0, rsp_err=0, busy=0, both ready=0.
REQ-027 Assertion of reset mid-operation (CMP or RESP) SHALL discard the transaction with no response issued.

Configuration
REQ-028 Macro COMP_ARB_FIXED_PRIO_EN: when defined, req0 SHALL always win contention and the pointer is removed; when undefined, round-robin per REQ-023.

Structure
REQ-029 Package comp_arb_pkg SHALL hold the FSM state enum, the op-code constants (OP_EQ..OP_GTE), and the all-ones false-code constant.
REQ-030 The block SHALL instantiate exactly one existing comparators sub-module (parameter N) fed from the operand registers.

Verification
REQ-031 Scenario: reset, req0 a=5 b=5 op=000, rsp_ready=1 -> rsp_valid 2 cycles after handshake, id=0, true=1, code=0x00.
REQ-032 Scenario: req1 a=3 b=9 op=100 -> true=0, code=0xFF, err=0.
REQ-033 Scenario: both valid continuously for 4 transactions -> grant order 0,1,0,1; with COMP_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-034 Scenario: op=110, a=1 b=1 -> err=1, true=0, code=0xFF.
REQ-035 Scenario: rsp_ready held low 5 cycles, a=7 b=2 op=101 -> rsp_* stable for all 5 cycles, no ready asserted, code=0x05 after release.
REQ-036 Scenario: reset_n pulsed low during CMP -> outputs at reset values immediately, no response ever appears for that request.
